// File: rtl/sram_like_bridge_pkg.sv
// Shared definitions for the SRAM-like bridge: FSM state encoding and bus size codes.
package sram_like_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_1B = 2'd0;
    localparam logic [1:0] SZ_2B = 2'd1;
    localparam logic [1:0] SZ_4B = 2'd2;
    localparam logic [1:0] SZ_8B = 2'd3;

    // Bus size field for a transfer of 2**log2Bytes bytes
    function automatic logic [1:0] sizeCode(input int log2Bytes);
        logic [1:0] s;
        case (log2Bytes)
            0:       s = SZ_1B;
            1:       s = SZ_2B;
            2:       s = SZ_4B;
            default: s = SZ_8B;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sram_like_bridge_if.sv
// SRAM-like bus between the bridge (master) and the memory-side slave.
interface sram_like_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_bridge_size_enc.sv
// Combinational strobe decoder: CPU byte strobes and address become bus size,
// aligned bus address, direction and a legality flag for the strobe pattern.
module sram_like_size_enc
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0] i_wen,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [1:0]          o_size,
    output logic [ADDR_W-1:0]   o_addr,
    output logic                o_wr,
    output logic                o_legal
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(NB - 1);

    logic [LB-1:0] w_firstByte;

    // Strobe group of 2**k bytes starting at byte off
    function automatic logic [NB-1:0] groupMask(input int k, input int off);
        logic [NB-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) begin
            if (b >= off && b < off + (1 << k)) m[b] = 1'b1;
        end
        return m;
    endfunction

    // A write is legal only if the strobes equal one naturally aligned group
    always_comb begin
        o_legal     = 1'b0;
        o_wr        = 1'b0;
        o_size      = sizeCode(LB);
        w_firstByte = '0;
        if (i_wen == '0) begin
            o_legal = 1'b1;
        end else begin
            o_wr = 1'b1;
            for (int k = 0; k <= LB; k++) begin
                for (int off = 0; off < NB; off += (1 << k)) begin
                    if (i_wen == groupMask(k, off)) begin
                        o_legal     = 1'b1;
                        o_size      = sizeCode(k);
                        w_firstByte = LB'(off);
                    end
                end
            end
        end
    end

    assign o_addr = (i_addr & ~LOW_MASK) | ADDR_W'(w_firstByte);

endmodule

// File: rtl/sram_like_bridge.sv
// CPU SRAM-style port to SRAM-like req/addr_ok/data_ok bus bridge with byte-strobe writes.
// Define SRAM_LIKE_TIMEOUT_EN to add a watchdog that aborts ADDR/DATA waits after TIMEOUT_CYCLES.
module sram_like_bridge
    import sram_like_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sram_en,
    input  logic [DATA_W/8-1:0] sram_wen,
    input  logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W-1:0]   sram_rdata,
    output logic                stall,
    output logic                err,
    input  logic                longest_stall,
    sram_like_if.master         bus
);
    if (DATA_W != 32 && DATA_W != 64) begin : g_badDataW
        $error("sram_like_bridge: DATA_W must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("sram_like_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            r_state, w_nextState;
    logic [1:0]        w_encSize, r_size;
    logic [ADDR_W-1:0] w_encAddr, r_addr;
    logic              w_encWr, w_encLegal, r_wr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              r_err;
    logic              w_idle, w_start, w_illegal, w_curWr, w_dataAccept, w_timeoutHit;

    sram_like_size_enc #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sizeEnc (
        .i_wen   (sram_wen),
        .i_addr  (sram_addr),
        .o_size  (w_encSize),
        .o_addr  (w_encAddr),
        .o_wr    (w_encWr),
        .o_legal (w_encLegal)
    );

    assign w_idle       = (r_state == ST_IDLE);
    assign w_start      = w_idle & sram_en & w_encLegal;
    assign w_illegal    = w_idle & sram_en & ~w_encLegal;
    assign w_curWr      = w_idle ? w_encWr : r_wr;
    assign w_dataAccept = (bus.req & bus.addr_ok & bus.data_ok)
                        | ((r_state == ST_DATA) & bus.data_ok);

`ifdef SRAM_LIKE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_waitCnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_waitCnt <= '0;
        end else if (r_state == ST_ADDR || r_state == ST_DATA) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end else begin
            r_waitCnt <= '0;
        end
    end

    // Handshake progress in the limit cycle wins over the watchdog
    assign w_timeoutHit = (r_waitCnt == CNT_W'(TIMEOUT_CYCLES))
                        & (((r_state == ST_ADDR) & ~bus.addr_ok)
                        |  ((r_state == ST_DATA) & ~bus.data_ok));
`else
    assign w_timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_illegal)                         w_nextState = ST_DONE;
                else if (w_start) begin
                    if (bus.addr_ok && bus.data_ok)    w_nextState = ST_DONE;
                    else if (bus.addr_ok)              w_nextState = ST_DATA;
                    else                               w_nextState = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.addr_ok && bus.data_ok)        w_nextState = ST_DONE;
                else if (bus.addr_ok)                  w_nextState = ST_DATA;
                else if (w_timeoutHit)                 w_nextState = ST_DONE;
            end
            ST_DATA: begin
                if (bus.data_ok || w_timeoutHit)       w_nextState = ST_DONE;
            end
            ST_DONE: begin
                if (!longest_stall)                    w_nextState = ST_IDLE;
            end
            default:                                   w_nextState = ST_IDLE;
        endcase
    end

    // In IDLE the encoder drives the bus directly; afterwards the latched copy holds it steady
    always_comb begin
        bus.req = resetn & (w_start | (r_state == ST_ADDR));
        stall   = sram_en & (r_state != ST_DONE);
        if (w_idle) begin
            bus.addr  = w_encAddr;
            bus.wr    = w_encWr;
            bus.size  = w_encSize;
            bus.wdata = sram_wdata;
        end else begin
            bus.addr  = r_addr;
            bus.wr    = r_wr;
            bus.size  = r_size;
            bus.wdata = r_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_size  <= SZ_1B;
            r_wdata <= '0;
        end else if (w_start) begin
            r_addr  <= w_encAddr;
            r_wr    <= w_encWr;
            r_size  <= w_encSize;
            r_wdata <= sram_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_dataAccept && !w_curWr) r_rdata <= bus.rdata;
            r_err <= w_illegal | w_timeoutHit;
        end
    end

    assign sram_rdata = r_rdata;
    assign err        = r_err;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: directed cases then randomized transactions
// against a transaction-level model; the watchdog case is built only with SRAM_LIKE_TIMEOUT_EN.
module tb_sram_like_bridge;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 8;
`ifdef SRAM_LIKE_TIMEOUT_EN
    localparam int WAIT_CYC = 5;
`else
    localparam int WAIT_CYC = 20;
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [31:0]       sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
    logic              stall;
    logic              err;
    logic              longest_stall;

    int                assertCount = 0;
    int                failCount   = 0;
    logic [31:0]       expRdata;

    sram_like_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_like_bridge #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .sram_en       (sram_en),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .stall         (stall),
        .err           (err),
        .longest_stall (longest_stall),
        .bus           (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference encoding from the strobe rules: popcount, first set byte, contiguity
    function automatic void modelEncode(input logic [3:0] wen, input logic [31:0] a,
                                        output bit legal, output logic [31:0] ea,
                                        output logic [1:0] esz, output bit ewr);
        int pc;
        int first;
        pc    = $countones(wen);
        first = 0;
        for (int i = 3; i >= 0; i--) if (wen[i]) first = i;
        if (pc == 0) begin
            legal = 1'b1;
            ewr   = 1'b0;
            ea    = a & ~32'h3;
            esz   = 2'd2;
        end else begin
            legal = (pc == 1 || pc == 2 || pc == 4) && (first % pc == 0)
                    && (wen == 4'(((1 << pc) - 1) << first));
            ewr   = 1'b1;
            ea    = (a & ~32'h3) | 32'(first);
            esz   = (pc == 1) ? 2'd0 : (pc == 2) ? 2'd1 : 2'd2;
        end
    endfunction

    // One CPU access: addr_ok after aokDelay cycles, data_ok dokDelay cycles later,
    // longest_stall held for lsHold DONE cycles, sram_en optionally dropped after cycle 0
    task automatic applyStimulus(input logic [3:0] wen, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int aokDelay, input int dokDelay,
                                 input int lsHold, input bit dropEn);
        bit          legal;
        bit          ewr;
        logic [31:0] ea;
        logic [1:0]  esz;
        int          cd;
        modelEncode(wen, a, legal, ea, esz, ewr);
        cd            = aokDelay + dokDelay;
        sram_en       = 1'b1;
        sram_wen      = wen;
        sram_addr     = a;
        sram_wdata    = wd;
        longest_stall = 1'b0;

        if (!legal) begin
            bus.addr_ok = 1'b0;
            bus.data_ok = 1'b0;
            #1;
            checkOutput("illegalReq", bus.req, 1'b0);
            checkOutput("illegalStall", stall, 1'b1);
            tick;
            #1;
            checkOutput("illegalErr", err, 1'b1);
            checkOutput("illegalDoneStall", stall, 1'b0);
            checkOutput("illegalDoneReq", bus.req, 1'b0);
            checkOutput("illegalRdata", sram_rdata, expRdata);
            sram_en = 1'b0;
            tick;
            #1;
            checkOutput("errPulseEnd", err, 1'b0);
            checkOutput("idleReq", bus.req, 1'b0);
            tick;
            return;
        end

        for (int c = 0; c <= cd; c++) begin
            if (dropEn && c > 0) begin
                sram_en    = 1'b0;
                sram_wen   = 4'($urandom);
                sram_addr  = $urandom;
                sram_wdata = $urandom;
            end
            bus.addr_ok = (c == aokDelay);
            bus.data_ok = (c == cd);
            bus.rdata   = (c == cd) ? rd : $urandom;
            #1;
            checkOutput("req", bus.req, (c <= aokDelay));
            if (c <= aokDelay) begin
                checkOutput("addr", bus.addr, ea);
                checkOutput("size", bus.size, esz);
                checkOutput("wr", bus.wr, ewr);
                checkOutput("wdata", bus.wdata, wd);
            end
            checkOutput("stall", stall, !(dropEn && c > 0));
            checkOutput("errNone", err, 1'b0);
            tick;
        end

        if (!ewr) expRdata = rd;
        bus.addr_ok = 1'b0;
        for (int i = 0; i < lsHold; i++) begin
            longest_stall = 1'b1;
            bus.data_ok   = 1'b1;
            bus.rdata     = $urandom;
            #1;
            checkOutput("holdStall", stall, 1'b0);
            checkOutput("holdReq", bus.req, 1'b0);
            checkOutput("holdRdata", sram_rdata, expRdata);
            checkOutput("holdErr", err, 1'b0);
            tick;
        end
        longest_stall = 1'b0;
        bus.data_ok   = 1'b1;
        bus.rdata     = $urandom;
        #1;
        checkOutput("doneStall", stall, 1'b0);
        checkOutput("doneReq", bus.req, 1'b0);
        checkOutput("doneRdata", sram_rdata, expRdata);
        checkOutput("doneErr", err, 1'b0);
        sram_en = 1'b0;
        tick;
        bus.rdata = $urandom;
        #1;
        checkOutput("idleReq", bus.req, 1'b0);
        checkOutput("idleStall", stall, 1'b0);
        tick;
        #1;
        checkOutput("idleRdataHeld", sram_rdata, expRdata);
        bus.data_ok = 1'b0;
        tick;
    endtask

    initial begin
        resetn        = 1'b0;
        sram_en       = 1'b0;
        sram_wen      = '0;
        sram_addr     = '0;
        sram_wdata    = '0;
        longest_stall = 1'b0;
        bus.addr_ok   = 1'b0;
        bus.data_ok   = 1'b0;
        bus.rdata     = '0;
        expRdata      = '0;
        tick;
        tick;
        checkOutput("rstRdata", sram_rdata, 32'h0);
        checkOutput("rstErr", err, 1'b0);
        checkOutput("rstReq", bus.req, 1'b0);
        checkOutput("rstStall", stall, 1'b0);
        sram_en = 1'b1;
        #1;
        checkOutput("rstReqGated", bus.req, 1'b0);
        sram_en = 1'b0;
        resetn  = 1'b1;
        tick;

        applyStimulus(4'b0000, 32'h0000_1003, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, 1'b0);
        applyStimulus(4'b1100, 32'h0000_2000, 32'hA5A5_1234, 32'h1111_2222, 0, 0, 0, 1'b0);
        applyStimulus(4'b1111, 32'h0000_3004, 32'h600D_F00D, 32'h3333_4444, 3, 1, 0, 1'b1);
        applyStimulus(4'b0000, 32'h0000_4008, 32'h0,         32'hCAFE_BABE, 1, 1, 4, 1'b0);
        applyStimulus(4'b0101, 32'h0000_5000, 32'h0,         32'h5555_6666, 0, 0, 0, 1'b0);
        applyStimulus(4'b0010, 32'h0000_7000, 32'h0000_AB00, 32'h7777_8888, 2, 0, 1, 1'b0);

`ifdef SRAM_LIKE_TIMEOUT_EN
        sram_en     = 1'b1;
        sram_wen    = 4'b0000;
        sram_addr   = 32'h0000_8000;
        bus.addr_ok = 1'b1;
        bus.data_ok = 1'b0;
        #1;
        checkOutput("toReq", bus.req, 1'b1);
        tick;
        bus.addr_ok = 1'b0;
        for (int c = 1; c <= TIMEOUT_CYCLES + 1; c++) begin
            #1;
            checkOutput("toWaitErr", err, 1'b0);
            checkOutput("toWaitStall", stall, 1'b1);
            tick;
        end
        #1;
        checkOutput("toErr", err, 1'b1);
        checkOutput("toStall", stall, 1'b0);
        checkOutput("toRdata", sram_rdata, expRdata);
        sram_en = 1'b0;
        tick;
        #1;
        checkOutput("toErrEnd", err, 1'b0);
        tick;
`endif

        // Reset asserted while waiting in DATA with sram_en still high
        sram_en     = 1'b1;
        sram_wen    = 4'b0000;
        sram_addr   = 32'h0000_6000;
        bus.addr_ok = 1'b1;
        bus.data_ok = 1'b0;
        #1;
        checkOutput("midReq", bus.req, 1'b1);
        tick;
        bus.addr_ok = 1'b0;
        for (int c = 0; c < WAIT_CYC; c++) begin
            #1;
            checkOutput("waitStall", stall, 1'b1);
            checkOutput("waitReq", bus.req, 1'b0);
            checkOutput("waitErr", err, 1'b0);
            tick;
        end
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("asyncRstReq", bus.req, 1'b0);
        checkOutput("asyncRstRdata", sram_rdata, 32'h0);
        checkOutput("asyncRstErr", err, 1'b0);
        expRdata = '0;
        sram_en  = 1'b0;
        tick;
        resetn = 1'b1;
        tick;

        for (int n = 0; n < 40; n++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            applyStimulus(w, $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_like_bridge.md
# sram_like_bridge

Parametrised CPU-side-SRAM to SRAM-like master bridge, usable for both the instruction and data ports of the pipeline. It converts a single-cycle SRAM-style access into an SRAM-like `req`/`addr_ok`/`data_ok` transaction and stalls the CPU until data returns. It holds the result until the pipeline-wide `longest_stall` releases. Compared with the instruction-only bridge, it adds writes with byte strobes, size/alignment derivation, request latching and an optional timeout.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; legal values 32 or 64
- `TIMEOUT_CYCLES`, 255, watchdog limit; used only when the timeout feature is compiled in

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, asynchronous, active-low
- `sram_en`  in  1  CPU access request
- `sram_wen`  in  DATA_W/8  byte write strobes; all zero means read
- `sram_addr`  in  ADDR_W  byte address
- `sram_wdata`  in  DATA_W  write data
- `sram_rdata`  out  DATA_W  captured read data
- `stall`  out  1  CPU stall
- `err`  out  1  one-cycle pulse on an illegal strobe pattern or a timeout
- `req`  out  1  SRAM-like request
- `wr`  out  1  1 = write
- `size`  out  2  log2 of the byte count (0=1B, 1=2B, 2=4B, 3=8B)
- `addr`  out  ADDR_W  bus address
- `wdata`  out  DATA_W  bus write data
- `addr_ok`  in  1  slave accepted the address
- `data_ok`  in  1  slave completed the transfer
- `rdata`  in  DATA_W  slave read data
- `longest_stall`  in  1  a pipeline stall is still active elsewhere

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- Combinational outputs:
  - `req = (IDLE & sram_en & legal) | ADDR`.
  - `stall = sram_en & ~DONE`.
- In IDLE, `addr`/`wr`/`size`/`wdata` are driven straight from the CPU inputs through the encoder.
- On the IDLE exit cycle, those values are latched. In ADDR, the latched values are driven, so `req` stays stable even if `sram_en` drops.
- Transitions:
  - IDLE & `req`: `addr_ok&data_ok` → DONE; `addr_ok` only → DATA; otherwise → ADDR.
  - ADDR: `addr_ok&data_ok` → DONE; `addr_ok` → DATA.
  - DATA: `data_ok` → DONE.
  - DONE: `~longest_stall` → IDLE; otherwise stay.
- `sram_rdata` loads `rdata` on every accepted `data_ok` for a read. It holds otherwise, including through DONE and IDLE.
- Write encoding:
  - Legal strobe patterns are: a single byte; an aligned pair; an aligned 4-byte group; all 8 bytes (64-bit only).
  - `size` follows the pattern, and `addr` is `sram_addr` with its low bits set to the first enabled byte.
  - `wdata` passes unchanged.
- Read encoding: `size` is log2(DATA_W/8), and `addr` is aligned down to DATA_W.
- Illegal strobe pattern in IDLE with `sram_en`:
  - No `req` is issued; `err` pulses.
  - FSM goes directly to DONE; `sram_rdata` is unchanged.
- A `data_ok` arriving in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, `sram_rdata`=0, `err`=0.
- Reset is asynchronous; asserting it mid-transaction returns the FSM to IDLE immediately and drops `req`.
- Minimum latency: one cycle. With `addr_ok&data_ok` in the request cycle, `stall` is high in that cycle and low in the next.
- Data is valid in `sram_rdata` from the first DONE cycle onward.
- While `longest_stall` is high in DONE, `stall` stays low and no new `req` is issued.

## Configuration
- Macro: `SRAM_LIKE_TIMEOUT_EN`.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears when leaving IDLE and increments in ADDR and DATA.
  - When it reaches TIMEOUT_CYCLES: `err` pulses, FSM goes to DONE, `sram_rdata` keeps its previous value.
- Undefined: no counter; ADDR and DATA wait indefinitely.

## Structure
- Package `sram_like_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_ADDR`, `ST_DATA`, `ST_DONE`);
  - size constants `SZ_1B`, `SZ_2B`, `SZ_4B`, `SZ_8B`.
- Sub-module `sram_like_size_enc` is purely combinational: (`wen`, `addr`) → (`size`, aligned `addr`, `wr`, `legal`).
- The FSM, latches and timeout live in the top module.

## Test plan
- Read, DATA_W=32, `sram_addr`=0x1003, slave returns `addr_ok` in cycle 0 and `data_ok`/0xDEADBEEF in cycle 2 → `addr`=0x1000, `size`=2, `stall` high for cycles 0–2, `sram_rdata`=0xDEADBEEF in cycle 3.
- Write, `wen`=4'b1100, `sram_addr`=0x2000, `addr_ok`&`data_ok` same cycle → `wr`=1, `size`=1, `addr`=0x2002, `stall` low in the next cycle.
- `addr_ok` withheld 3 cycles while `sram_en` drops after cycle 0 → `req`, `addr`, `wdata` stable all 4 cycles.
- `data_ok` arrives with `longest_stall` high for 4 cycles → FSM stays in DONE, no `req`, `sram_rdata` held, returns to IDLE after release.
- `wen`=4'b0101 → no `req`, one `err` pulse, `stall` low in the next cycle.
- With `SRAM_LIKE_TIMEOUT_EN` and TIMEOUT_CYCLES=8, `addr_ok` given but no `data_ok` → `err` pulses after 8 wait cycles; `resetn` pulsed low in a later DATA state → IDLE with `req`=0 immediately.
